axis_burst_gate: RTL and testbench

- Sits directly downstream of the 128-bit AXIS FIFO wrapper.
- Consumes the wrapper's M_AXIS stream and 32-bit data_count.
- Releases data to the DMA/host side only as fixed-length bursts terminated by TLAST.
- If data sits unsent too long, or on an explicit flush request, sends a shorter (partial) burst instead.

---
 rtl/axis_burst_gate.sv | 149 ++++++++++++++
 tb/tb_axis_burst_gate.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_burst_gate.sv
// Cuts a FIFO AXIS stream into BURST_LEN-beat TLAST bursts, or shorter ones on flush or idle timeout; 1-cycle IDLE decision, zero-latency BURST pass-through.
// Both sides may stall a burst, and it holds until complete. `AXIS_BURST_GATE_STATS_EN adds burst/partial counters, otherwise tied to 0.
module axis_burst_gate #(
  parameter int unsigned TDATA_WIDTH    = 128,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned LEN_WIDTH      = $clog2(BURST_LEN) + 1
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  input  logic [31:0]            fifo_count,
  input  logic                   flush,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic                   M_AXIS_TLAST,
  output logic                   busy,
  output logic [31:0]            burst_count,
  output logic [31:0]            partial_count
);

  localparam int unsigned          TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TMR_WIDTH-1:0] TMR_MAX   = TMR_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [LEN_WIDTH-1:0] FULL_LEN  = LEN_WIDTH'(BURST_LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [TMR_WIDTH-1:0] timer_q, timer_d;
  logic                 flush_pend_q, flush_pend_d;

  logic in_burst;
  logic hs;
  logic last_beat;
  logic burst_done;
  logic have_data;
  logic is_full;
  logic timed_out;
  logic enter_full;
  logic enter_partial;

  always_comb begin
    in_burst      = (state_q == BURST);
    hs            = in_burst & S_AXIS_TVALID & M_AXIS_TREADY;
    last_beat     = (beats_left_q == LEN_WIDTH'(1));
    burst_done    = hs & last_beat;
    have_data     = (fifo_count != 32'd0);
    is_full       = (fifo_count >= 32'(BURST_LEN));
    timed_out     = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_MAX);
    enter_full    = !in_burst && is_full;
    enter_partial = !in_burst && !is_full && have_data &&
                    (flush_pend_q || flush || timed_out);
  end

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    timer_d      = timer_q;
    flush_pend_d = flush_pend_q;
    if (in_burst) begin
      // A committed burst waits for TVALID; no timeout applies here.
      if (hs) begin
        beats_left_d = beats_left_q - LEN_WIDTH'(1);
        if (last_beat) begin
          state_d = IDLE;
        end
      end
    end else if (enter_full) begin
      // A flush arriving with a full burst is kept for the leftover data.
      state_d      = BURST;
      beats_left_d = FULL_LEN;
      timer_d      = '0;
      flush_pend_d = flush_pend_q | flush;
    end else if (enter_partial) begin
      state_d      = BURST;
      beats_left_d = fifo_count[LEN_WIDTH-1:0];
      timer_d      = '0;
      flush_pend_d = 1'b0;
    end else if (!have_data) begin
      timer_d      = '0;
      flush_pend_d = 1'b0;
    end else begin
      if (timer_q != TMR_MAX) begin
        timer_d = timer_q + TMR_WIDTH'(1);
      end
      if (flush) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign busy          = in_burst;
  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TVALID = in_burst & S_AXIS_TVALID;
  assign S_AXIS_TREADY = in_burst & M_AXIS_TREADY;
  assign M_AXIS_TLAST  = in_burst & last_beat;

`ifdef AXIS_BURST_GATE_STATS_EN
  logic        partial_q;
  logic [31:0] burst_cnt_q;
  logic [31:0] partial_cnt_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      partial_q     <= 1'b0;
      burst_cnt_q   <= '0;
      partial_cnt_q <= '0;
    end else begin
      if (enter_full || enter_partial) begin
        partial_q <= enter_partial;
      end
      if (burst_done) begin
        burst_cnt_q <= burst_cnt_q + 32'd1;
        if (partial_q) begin
          partial_cnt_q <= partial_cnt_q + 32'd1;
        end
      end
    end
  end

  assign burst_count   = burst_cnt_q;
  assign partial_count = partial_cnt_q;
`else
  assign burst_count   = 32'd0;
  assign partial_count = 32'd0;
`endif

endmodule

// File: tb/tb_axis_burst_gate.sv
// Directed bench: two gates (timeout 8 and timeout 0) share one upstream FIFO model; sel picks which one pops it and is observed.
module tb_axis_burst_gate;

`ifdef AXIS_BURST_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         aclk = 1'b0;
  logic         areset;
  logic [127:0] S_AXIS_TDATA;
  logic         S_AXIS_TVALID;
  logic [31:0]  fifo_count;
  logic         flush;
  logic         M_AXIS_TREADY;

  logic [127:0] d_mdat, z_mdat;
  logic         d_srdy, z_srdy, d_mvld, z_mvld, d_mlast, z_mlast, d_busy, z_busy;
  logic [31:0]  d_bcnt, z_bcnt, d_pcnt, z_pcnt;

  bit           sel = 1'b0;
  logic [127:0] o_mdat;
  logic         o_srdy, o_mvld, o_mlast, o_busy;
  logic [31:0]  o_bcnt, o_pcnt;

  assign o_mdat  = sel ? z_mdat  : d_mdat;
  assign o_srdy  = sel ? z_srdy  : d_srdy;
  assign o_mvld  = sel ? z_mvld  : d_mvld;
  assign o_mlast = sel ? z_mlast : d_mlast;
  assign o_busy  = sel ? z_busy  : d_busy;
  assign o_bcnt  = sel ? z_bcnt  : d_bcnt;
  assign o_pcnt  = sel ? z_pcnt  : d_pcnt;

  always #5 aclk = ~aclk;

  axis_burst_gate #(.TDATA_WIDTH(128), .BURST_LEN(16), .TIMEOUT_CYCLES(8)) u_dut (
    .aclk(aclk), .areset(areset),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(d_srdy),
    .fifo_count(fifo_count), .flush(flush),
    .M_AXIS_TDATA(d_mdat), .M_AXIS_TVALID(d_mvld), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST(d_mlast), .busy(d_busy), .burst_count(d_bcnt), .partial_count(d_pcnt)
  );

  axis_burst_gate #(.TDATA_WIDTH(128), .BURST_LEN(16), .TIMEOUT_CYCLES(0)) u_dut_z (
    .aclk(aclk), .areset(areset),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(z_srdy),
    .fifo_count(fifo_count), .flush(flush),
    .M_AXIS_TDATA(z_mdat), .M_AXIS_TVALID(z_mvld), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST(z_mlast), .busy(z_busy), .burst_count(z_bcnt), .partial_count(z_pcnt)
  );

  int           total = 0;
  int           bad   = 0;
  logic [127:0] fq[$];
  logic [127:0] beat_dat[$];
  logic         beat_last[$];
  int           beat_cyc[$];
  int           busy_cyc;
  int           tlast_cyc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic drive_fifo();
    S_AXIS_TVALID = (fq.size() != 0);
    S_AXIS_TDATA  = (fq.size() != 0) ? fq[0] : '0;
    fifo_count    = 32'(fq.size());
  endtask

  task automatic push(input int base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(128'(base + i));
    drive_fifo();
  endtask

  // One call = ncyc clock cycles; inputs change at posedge+1, outputs sampled at posedge+2.
  task automatic run_collect(input int ncyc, input bit flush0, input bit toggle);
    bit hs;
    beat_dat.delete();
    beat_last.delete();
    beat_cyc.delete();
    busy_cyc  = 0;
    tlast_cyc = 0;
    for (int c = 0; c < ncyc; c++) begin
      flush = flush0 && (c == 0);
      if (toggle) M_AXIS_TREADY = ((c % 2) == 0);
      drive_fifo();
      #1;
      if (o_busy) begin
        busy_cyc++;
        chk("s_rdy_track", 128'(o_srdy), 128'(M_AXIS_TREADY));
      end
      if (o_mvld && o_mlast) tlast_cyc++;
      if (o_mvld && M_AXIS_TREADY) begin
        beat_dat.push_back(o_mdat);
        beat_last.push_back(o_mlast);
        beat_cyc.push_back(c);
      end
      hs = o_srdy && S_AXIS_TVALID;
      @(posedge aclk);
      #1;
      if (hs) void'(fq.pop_front());
    end
    flush = 1'b0;
    drive_fifo();
  endtask

  task automatic chk_beats(input string tag, input int base, input int n, input int last1, input int last2);
    chk({tag, "_nbeats"}, 128'(beat_dat.size()), 128'(n));
    for (int i = 0; i < n && i < beat_dat.size(); i++) begin
      chk({tag, "_dat"}, beat_dat[i], 128'(base + i));
      chk({tag, "_last"}, 128'(beat_last[i]), 128'((i == last1) || (i == last2)));
    end
  endtask

  initial begin
    areset        = 1'b1;
    flush         = 1'b0;
    M_AXIS_TREADY = 1'b0;
    drive_fifo();
    @(posedge aclk);
    @(posedge aclk);
    #1;
    chk("rst_busy", 128'(o_busy), 128'd0);
    chk("rst_mvld", 128'(o_mvld), 128'd0);
    chk("rst_mlast", 128'(o_mlast), 128'd0);
    chk("rst_srdy", 128'(o_srdy), 128'd0);
    chk("rst_bcnt", 128'(o_bcnt), 128'd0);
    chk("rst_pcnt", 128'(o_pcnt), 128'd0);
    areset        = 1'b0;
    M_AXIS_TREADY = 1'b1;

    // Full burst: 16 beats back-to-back after the decision cycle.
    push(32'h1000, 16);
    run_collect(20, 1'b0, 1'b0);
    chk_beats("full", 32'h1000, 16, 15, 15);
    chk("full_busy_cycles", 128'(busy_cyc), 128'd16);
    chk("full_first_cyc", 128'(beat_cyc[0]), 128'd1);
    chk("full_last_cyc", 128'(beat_cyc[15]), 128'd16);
    chk("full_bcnt", 128'(o_bcnt), 128'(cexp(1)));
    chk("full_pcnt", 128'(o_pcnt), 128'(cexp(0)));

    // Timeout: timer hits 8 after 8 cycles, burst begins on the next.
    push(32'h2000, 3);
    run_collect(16, 1'b0, 1'b0);
    chk_beats("tmo", 32'h2000, 3, 2, 2);
    chk("tmo_first_cyc", 128'(beat_cyc[0]), 128'd9);
    chk("tmo_busy_cycles", 128'(busy_cyc), 128'd3);
    chk("tmo_bcnt", 128'(o_bcnt), 128'(cexp(2)));
    chk("tmo_pcnt", 128'(o_pcnt), 128'(cexp(1)));

    // Flush with toggling ready: beats at cycles 2,4,6,8,10; TLAST held over 9..10.
    push(32'h3000, 5);
    run_collect(14, 1'b1, 1'b1);
    M_AXIS_TREADY = 1'b1;
    chk_beats("flush", 32'h3000, 5, 4, 4);
    chk("flush_first_cyc", 128'(beat_cyc[0]), 128'd2);
    chk("flush_last_cyc", 128'(beat_cyc[4]), 128'd10);
    chk("flush_tlast_cycles", 128'(tlast_cyc), 128'd2);
    chk("flush_busy_cycles", 128'(busy_cyc), 128'd10);
    chk("flush_bcnt", 128'(o_bcnt), 128'(cexp(3)));
    chk("flush_pcnt", 128'(o_pcnt), 128'(cexp(2)));

    // Full and flush together: 16-beat burst, one idle cycle, then the 4 leftovers.
    push(32'h4000, 20);
    run_collect(26, 1'b1, 1'b0);
    chk_beats("both", 32'h4000, 20, 15, 19);
    chk("both_b1_end_cyc", 128'(beat_cyc[15]), 128'd16);
    chk("both_b2_start_cyc", 128'(beat_cyc[16]), 128'd18);
    chk("both_bcnt", 128'(o_bcnt), 128'(cexp(5)));
    chk("both_pcnt", 128'(o_pcnt), 128'(cexp(3)));

    // Reset mid-burst on the timeout-disabled gate.
    sel    = 1'b1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    push(32'h5000, 16);
    run_collect(8, 1'b0, 1'b0);
    chk("rmid_beats_before", 128'(beat_dat.size()), 128'd7);
    chk("rmid_busy_before", 128'(o_busy), 128'd1);
    M_AXIS_TREADY = 1'b0;
    areset        = 1'b1;
    @(posedge aclk);
    #1;
    areset        = 1'b0;
    M_AXIS_TREADY = 1'b1;
    #1;
    chk("rmid_busy", 128'(o_busy), 128'd0);
    chk("rmid_mvld", 128'(o_mvld), 128'd0);
    chk("rmid_mlast", 128'(o_mlast), 128'd0);
    chk("rmid_bcnt", 128'(o_bcnt), 128'd0);
    chk("rmid_pcnt", 128'(o_pcnt), 128'd0);
    run_collect(30, 1'b0, 1'b0);
    chk("rmid_hold_busy", 128'(busy_cyc), 128'd0);
    chk("rmid_hold_beats", 128'(beat_dat.size()), 128'd0);
    push(32'h5010, 7);
    run_collect(20, 1'b0, 1'b0);
    chk_beats("rmid_new", 32'h5007, 16, 15, 15);
    chk("rmid_new_bcnt", 128'(o_bcnt), 128'(cexp(1)));

    // Timeout disabled: data sits for 5000 cycles until a flush.
    push(32'h6000, 2);
    run_collect(5000, 1'b0, 1'b0);
    chk("t0_idle_busy", 128'(busy_cyc), 128'd0);
    chk("t0_idle_beats", 128'(beat_dat.size()), 128'd0);
    run_collect(6, 1'b1, 1'b0);
    chk_beats("t0_flush", 32'h6000, 2, 1, 1);
    chk("t0_first_cyc", 128'(beat_cyc[0]), 128'd1);
    chk("t0_bcnt", 128'(o_bcnt), 128'(cexp(2)));
    chk("t0_pcnt", 128'(o_pcnt), 128'(cexp(1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
